// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with mcycle/minstret counters and read-only shadows
module csr_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int COUNTER_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = 32'h00000040
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] ir_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic                  retire_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  illegal_o
);
  localparam int HW = COUNTER_WIDTH - 32;
  logic [11:0] addr;
  logic [2:0] f3;
  logic [4:0] zimm;
  logic [DATA_WIDTH-1:0] mscratch, mtvec, mepc, mcause, rval, op, wval;
  logic [COUNTER_WIDTH-1:0] mcycle, minstret;
  logic cy_inh, ir_inh, hit, nop, ro, illegal, we;
  logic unused_ir;
  assign addr = ir_i[31:20];
  assign f3 = ir_i[14:12];
  assign zimm = ir_i[19:15];
  assign unused_ir = ^ir_i[11:0];
  // Current value of the addressed CSR; hit marks an implemented address
  always_comb begin
    hit = 1'b1;
    rval = '0;
    case (addr)
      12'h340: rval = mscratch;
      12'h305: rval = mtvec;
      12'h341: rval = mepc;
      12'h342: rval = mcause;
      12'h320: rval = DATA_WIDTH'({ir_inh, 1'b0, cy_inh});
      12'hB00, 12'hC00: rval = DATA_WIDTH'(mcycle[31:0]);
      12'hB80, 12'hC80: rval = DATA_WIDTH'(mcycle[COUNTER_WIDTH-1:32]);
      12'hB02, 12'hC02: rval = DATA_WIDTH'(minstret[31:0]);
      12'hB82, 12'hC82: rval = DATA_WIDTH'(minstret[COUNTER_WIDTH-1:32]);
      default: hit = 1'b0;
    endcase
  end
  // Operand selection, set/clear with rs1==0 suppressed, legality and new value
  always_comb begin
    op = f3[2] ? DATA_WIDTH'(zimm) : data_i;
    nop = f3[1] && zimm == 5'd0;
    ro = addr[11:10] == 2'b11;
    illegal = ((rd_i || wr_i) && !hit) || (wr_i && (f3[1:0] == 2'b00 || (ro && !nop)));
    we = wr_i && hit && f3[1:0] != 2'b00 && !ro && !nop;
    wval = f3[1:0] == 2'b01 ? op : f3[1:0] == 2'b10 ? (rval | op) : (rval & ~op);
  end
  // Registered read port: old value on read, zero and pulse on illegal access
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= illegal;
      if (rd_i) data_o <= hit ? rval : '0;
    end
  end
  // Plain machine CSRs; mtvec/mepc keep their low two bits clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mscratch <= '0;
      mtvec <= {RESET_MTVEC[DATA_WIDTH-1:2], 2'b00};
      mepc <= '0;
      mcause <= '0;
      cy_inh <= 1'b0;
      ir_inh <= 1'b0;
    end else if (we) begin
      if (addr == 12'h340) mscratch <= wval;
      if (addr == 12'h305) mtvec <= {wval[DATA_WIDTH-1:2], 2'b00};
      if (addr == 12'h341) mepc <= {wval[DATA_WIDTH-1:2], 2'b00};
      if (addr == 12'h342) mcause <= wval;
      if (addr == 12'h320) {ir_inh, cy_inh} <= {wval[2], wval[0]};
    end
  end
  // Counters: a write to either half wins over the increment for that cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mcycle <= '0;
      minstret <= '0;
    end else begin
      mcycle <= we && addr == 12'hB00 ? {mcycle[COUNTER_WIDTH-1:32], wval[31:0]} :
                we && addr == 12'hB80 ? {wval[HW-1:0], mcycle[31:0]} :
                mcycle + COUNTER_WIDTH'(!cy_inh);
      minstret <= we && addr == 12'hB02 ? {minstret[COUNTER_WIDTH-1:32], wval[31:0]} :
                  we && addr == 12'hB82 ? {wval[HW-1:0], minstret[31:0]} :
                  minstret + COUNTER_WIDTH'(retire_i && !ir_inh);
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: scoreboard bench for csr_unit; read results are queued at issue, checked on the next edge
module tb_csr_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ir = '0, data = '0, dout;
  logic rd = 1'b0, wr = 1'b0, retire = 1'b0, illegal;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int tests = 0, fails = 0;

  csr_unit dut (.clk_i(clk), .reset_i(reset), .ir_i(ir), .data_i(data), .rd_i(rd), .wr_i(wr),
                .retire_i(retire), .data_o(dout), .illegal_o(illegal));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic op(input logic [11:0] a, input logic [2:0] f, input logic [4:0] rs,
                    input logic [31:0] d, input logic r, input logic w, input logic ret);
    ir = {a, rs, f, 5'd1, 7'h73};
    data = d;
    rd = r;
    wr = w;
    retire = ret;
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    retire = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected %h", dout, 32'h0); end
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    exp_q.push_back(32'd10); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mcycle_after_10: got %h expected %h", dout, e); end
    exp_q.push_back(32'h0); op(12'hB80, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mcycleh_reset: got %h expected %h", dout, e); end
    exp_q.push_back(32'h40); op(12'h305, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mtvec_reset: got %h expected %h", dout, e); end
    #2 reset = 1'b1;
    #1;
    tests++; if (dout !== 32'h0) begin fails++; $display("FAIL async_reset_data: got %h expected %h", dout, 32'h0); end
    op(12'h305, 3'b010, 5'd0, 0, 1, 0, 1);
    tests++; if (dout !== 32'h0) begin fails++; $display("FAIL rd_ignored_in_reset: got %h expected %h", dout, 32'h0); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd1); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL first_edge_mcycle: got %h expected %h", dout, e); end
  endtask

  task automatic test_mscratch();
    op(12'h340, 3'b001, 5'd1, 32'hDEADBEEF, 0, 1, 0);
    exp_q.push_back(32'hDEADBEEF); op(12'h340, 3'b010, 5'd1, 32'h0000000F, 1, 1, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL csrrw_value: got %h expected %h", dout, e); end
    exp_q.push_back(32'hDEADBEEF); op(12'h340, 3'b111, 5'd3, 32'hFFFFFFFF, 1, 1, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL csrrs_value: got %h expected %h", dout, e); end
    exp_q.push_back(32'hDEADBEEC); op(12'h340, 3'b010, 5'd0, 32'hFFFFFFFF, 1, 1, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL csrrci_value: got %h expected %h", dout, e); end
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL csrrs_rs0_illegal: got %b expected 0", illegal); end
    exp_q.push_back(32'hDEADBEEC); op(12'h340, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL csrrs_rs0_nowrite: got %h expected %h", dout, e); end
    op(12'h340, 3'b000, 5'd1, 32'h12345678, 0, 1, 0);
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL funct3_000_illegal: got %b expected 1", illegal); end
    exp_q.push_back(32'hDEADBEEC); op(12'h340, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL funct3_000_nowrite: got %h expected %h", dout, e); end
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_one_cycle: got %b expected 0", illegal); end
  endtask

  task automatic test_illegal();
    exp_q.push_back(32'h0); op(12'h7FF, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL unimpl_read_data: got %h expected %h", dout, e); end
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL unimpl_read_illegal: got %b expected 1", illegal); end
    op(12'h305, 3'b001, 5'd1, 32'h00000103, 0, 1, 0);
    exp_q.push_back(32'h100); op(12'h305, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mtvec_low_bits: got %h expected %h", dout, e); end
    op(12'h341, 3'b001, 5'd1, 32'hFFFFFFFF, 0, 1, 0);
    exp_q.push_back(32'hFFFFFFFC); op(12'h341, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mepc_low_bits: got %h expected %h", dout, e); end
    op(12'h342, 3'b001, 5'd1, 32'h8000000B, 0, 1, 0);
    exp_q.push_back(32'h8000000B); op(12'h342, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mcause_rw: got %h expected %h", dout, e); end
    op(12'h320, 3'b001, 5'd1, 32'hFFFFFFFF, 0, 1, 0);
    exp_q.push_back(32'h5); op(12'h320, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL mcountinhibit_mask: got %h expected %h", dout, e); end
    op(12'h320, 3'b001, 5'd1, 32'h0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    op(12'h340, 3'b001, 5'd1, 32'h11111111, 0, 1, 0);
    op(12'h341, 3'b001, 5'd1, 32'h22222223, 0, 1, 0);
    op(12'h342, 3'b001, 5'd1, 32'h33333333, 0, 1, 0);
    exp_q.push_back(32'h11111111); op(12'h340, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL b2b_mscratch: got %h expected %h", dout, e); end
    exp_q.push_back(32'h22222220); op(12'h341, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL b2b_mepc: got %h expected %h", dout, e); end
    exp_q.push_back(32'h33333333); op(12'h342, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL b2b_mcause: got %h expected %h", dout, e); end
  endtask

  task automatic test_wrap();
    op(12'hB00, 3'b001, 5'd1, 32'hFFFFFFFF, 0, 1, 0);
    op(12'hB80, 3'b001, 5'd1, 32'hFFFFFFFF, 0, 1, 0);
    op(12'h000, 3'b000, 5'd0, 0, 0, 0, 0);
    exp_q.push_back(32'h0); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL wrap_mcycle: got %h expected %h", dout, e); end
    exp_q.push_back(32'h0); op(12'hB80, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL wrap_mcycleh: got %h expected %h", dout, e); end
  endtask

  task automatic test_readonly();
    apply_reset();
    op(12'hC00, 3'b001, 5'd1, 32'h5, 0, 1, 0);
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ro_write_illegal: got %b expected 1", illegal); end
    op(12'h000, 3'b000, 5'd0, 0, 0, 0, 0);
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ro_illegal_pulse: got %b expected 0", illegal); end
    exp_q.push_back(32'd2); op(12'hC00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL ro_counter_kept: got %h expected %h", dout, e); end
    op(12'hC00, 3'b010, 5'd0, 32'hFFFFFFFF, 0, 1, 0);
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ro_csrrs_rs0: got %b expected 0", illegal); end
    op(12'hC00, 3'b011, 5'd0, 32'hFFFFFFFF, 0, 1, 0);
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ro_csrrc_rs0: got %b expected 0", illegal); end
    exp_q.push_back(32'd5); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL ro_rs0_nowrite: got %h expected %h", dout, e); end
  endtask

  task automatic test_inhibit();
    apply_reset();
    op(12'h320, 3'b001, 5'd1, 32'h5, 0, 1, 0);
    for (int i = 0; i < 8; i++) op(12'h000, 3'b000, 5'd0, 0, 0, 0, (i % 2 == 0) || i == 7);
    exp_q.push_back(32'd1); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 1);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL inhibit_mcycle: got %h expected %h", dout, e); end
    exp_q.push_back(32'd0); op(12'hB02, 3'b010, 5'd0, 0, 1, 0, 1);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL inhibit_minstret: got %h expected %h", dout, e); end
    op(12'h320, 3'b011, 5'd1, 32'h5, 0, 1, 1);
    exp_q.push_back(32'd1); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 1);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL inhibit_clear_edge: got %h expected %h", dout, e); end
    exp_q.push_back(32'd1); op(12'hB02, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL resume_minstret: got %h expected %h", dout, e); end
    exp_q.push_back(32'd3); op(12'hB00, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL resume_mcycle: got %h expected %h", dout, e); end
    exp_q.push_back(32'd0); op(12'hB82, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL minstreth_zero: got %h expected %h", dout, e); end
  endtask

  task automatic test_reset_mid_write();
    op(12'h305, 3'b001, 5'd1, 32'h200, 0, 1, 0);
    op(12'h340, 3'b001, 5'd1, 32'hAA, 0, 1, 0);
    ir = {12'h305, 5'd1, 3'b001, 5'd1, 7'h73};
    data = 32'h300;
    wr = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h40); op(12'h305, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL midwrite_mtvec: got %h expected %h", dout, e); end
    exp_q.push_back(32'h0); op(12'h340, 3'b010, 5'd0, 0, 1, 0, 0);
    e = exp_q.pop_front(); tests++; if (dout !== e) begin fails++; $display("FAIL midwrite_mscratch: got %h expected %h", dout, e); end
  endtask

  initial begin
    test_reset();
    test_mscratch();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_readonly();
    test_inhibit();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
